// File: rtl/ls374_bus_sequencer_pkg.sv
// Shared state encoding and sizing helpers for the ls374 bus sequencer.
// Imported by the interface, the round-robin arbiter and the top level.
package ls374_bus_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_STROBE,
    ST_RELEASE,
    ST_TURN
  } state_e;

  localparam int DEF_N      = 4;
  localparam int DEF_R      = 4;
  localparam int DEF_SETTLE = 2;
  localparam int DEF_TURN   = 1;

  // Index width, never below one bit so single-entry banks still have a port.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int settle, input int turn);
    int m;
    m = (settle > turn) ? settle : turn;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ls374_bus_sequencer_if.sv
// Request/grant and register-bank control bundle between requesters and the sequencer.
// The master side issues transfers; the slave side (the sequencer) drives grants and strobes.
interface ls374_bus_sequencer_if
  import ls374_bus_sequencer_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int R    = DEF_R,
  parameter int IDXW = idx_w(DEF_R)
);
  logic [N-1:0]      req;
  logic [N*IDXW-1:0] xfer_src;
  logic [N*IDXW-1:0] xfer_dst;
  logic [N-1:0]      gnt;
  logic [N-1:0]      done;
  logic              err;
  logic [R-1:0]      oe_;
  logic [R-1:0]      ld;
  logic              busy;

  modport master (
    output req, xfer_src, xfer_dst,
    input  gnt, done, err, oe_, ld, busy
  );

  modport slave (
    input  req, xfer_src, xfer_dst,
    output gnt, done, err, oe_, ld, busy
  );
endinterface

// File: rtl/ls374_bus_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
// Zero latency; the caller registers the result and advances the pointer.
module ls374_bus_sequencer_rr_arbiter
  import ls374_bus_sequencer_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int PW = idx_w(DEF_N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [PW-1:0] gnt_idx_o,
  output logic          any_o
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_i) + i) % N);
      if (!any_o && req_i[idx]) begin
        any_o          = 1'b1;
        gnt_oh_o[idx]  = 1'b1;
        gnt_idx_o      = idx;
      end
    end
  end

endmodule

// File: rtl/ls374_bus_sequencer.sv
// Arbitrates register-to-register transfers on a shared 3-state bus; period SETTLE+TURN+3 cycles.
// Requesters hold req until done; one grant per idle visit, at most one register drives the bus.
module ls374_bus_sequencer
  import ls374_bus_sequencer_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int R      = DEF_R,
  parameter int SETTLE = DEF_SETTLE,
  parameter int TURN   = DEF_TURN
) (
  input  logic                 cp,
  input  logic                 mr_,
  ls374_bus_sequencer_if.slave bus
);

  localparam int IDXW = idx_w(R);
  localparam int PW   = idx_w(N);
  localparam int CW   = cnt_w(SETTLE, TURN);

  state_e          state_q;
  logic [PW-1:0]   ptr_q;
  logic [IDXW-1:0] src_q, dst_q;
  logic            rej_q;
  logic [CW-1:0]   cnt_q;
  logic [R-1:0]    oe_q, ld_q;
  logic [N-1:0]    gnt_q, done_q;
  logic            err_q, busy_q;

  logic [N-1:0]    arb_oh;
  logic [PW-1:0]   arb_idx;
  logic            arb_any;
  logic [IDXW-1:0] src_d, dst_d;
  logic            valid_d;
  logic [PW-1:0]   ptr_d;

  ls374_bus_sequencer_rr_arbiter #(.N(N), .PW(PW)) u_arb (
    .req_i     (bus.req),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx),
    .any_o     (arb_any)
  );

  always_comb begin
    src_d   = bus.xfer_src[int'(arb_idx)*IDXW +: IDXW];
    dst_d   = bus.xfer_dst[int'(arb_idx)*IDXW +: IDXW];
    valid_d = (int'(src_d) < R) && (int'(dst_d) < R) && (src_d != dst_d);
    ptr_d   = (int'(arb_idx) == N - 1) ? '0 : arb_idx + 1'b1;
  end

  always_ff @(posedge cp or negedge mr_) begin
    if (!mr_) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      rej_q   <= 1'b0;
      cnt_q   <= '0;
      oe_q    <= '1;
      ld_q    <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      ld_q   <= '0;
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            gnt_q  <= arb_oh;
            busy_q <= 1'b1;
            src_q  <= src_d;
            dst_q  <= dst_d;
            ptr_q  <= ptr_d;
            if (valid_d) begin
              state_q <= ST_DRIVE;
              rej_q   <= 1'b0;
              oe_q    <= ~(R'(1) << src_d);
              cnt_q   <= CW'(SETTLE - 1);
            end else begin
              // Rejected requests skip the bus entirely and complete at once.
              state_q <= ST_RELEASE;
              rej_q   <= 1'b1;
              done_q  <= arb_oh;
              err_q   <= 1'b1;
            end
          end
        end
        ST_DRIVE: begin
          if (cnt_q == '0) begin
            state_q <= ST_STROBE;
            oe_q    <= ~(R'(1) << src_q);
            ld_q    <= R'(1) << dst_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_STROBE: begin
          // ld falls on this edge while oe_ releases, so the capture sees a driven bus.
          state_q <= ST_RELEASE;
          oe_q    <= '1;
          done_q  <= gnt_q;
          err_q   <= rej_q;
        end
        ST_RELEASE: begin
          gnt_q <= '0;
          if (TURN == 0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_TURN;
            cnt_q   <= CW'(TURN - 1);
          end
        end
        ST_TURN: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          oe_q    <= '1;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oe_  = oe_q;
  assign bus.ld   = ld_q;
  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_ls374_bus_sequencer.sv
// Bench for ls374_bus_sequencer: register-array model on the bus plus a round-robin reference.
module tb_ls374_bus_sequencer;

  localparam int N    = 4;
  localparam int R    = 4;
  localparam int S    = 2;
  localparam int T    = 1;
  localparam int IDXW = 2;
  localparam int PER  = S + T + 3;

  logic cp;
  logic mr_;

  ls374_bus_sequencer_if #(.N(N), .R(R), .IDXW(IDXW)) bus ();

  ls374_bus_sequencer #(.N(N), .R(R), .SETTLE(S), .TURN(T)) dut (
    .cp  (cp),
    .mr_ (mr_),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int m_ptr = 0;

  logic [7:0]   chip [R];
  logic [7:0]   bus_prev;
  logic [R-1:0] ld_prev;
  int           idle_run, prev_lows, prev_drv;
  bit           drv_seen;

  initial cp = 1'b0;
  always #5 cp = ~cp;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge cp);
    #1;
    cyc++;
  endtask

  // Round-robin reference: first asserted requester at or after the pointer.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic set_xfer(input int who, input int s, input int d);
    bus.xfer_src[who*IDXW +: IDXW] = IDXW'(s);
    bus.xfer_dst[who*IDXW +: IDXW] = IDXW'(d);
  endtask

  // Models the octal registers: capture the driven bus on the falling edge of ld.
  always @(negedge cp) begin
    int lows, drv;
    if (!mr_) begin
      idle_run = 0; drv_seen = 0; ld_prev = '0; prev_lows = 0; prev_drv = -1;
    end else begin
      lows = 0; drv = -1;
      for (int j = 0; j < R; j++) if (!bus.oe_[j]) begin lows++; drv = j; end
      total++;
      if (lows > 1) begin bad++; $display("FAIL oe_onehot: oe_=%b", bus.oe_); end
      if (bus.ld != '0) begin
        total++;
        if (lows != 1) begin bad++; $display("FAIL ld_undriven: ld=%b oe_=%b", bus.ld, bus.oe_); end
      end
      for (int j = 0; j < R; j++) if (ld_prev[j] && !bus.ld[j]) chip[j] = bus_prev;
      if (lows == 1 && prev_lows == 0 && drv_seen) begin
        total++;
        if (idle_run < T + 1) begin bad++; $display("FAIL turnaround: idle=%0d need>=%0d", idle_run, T + 1); end
      end
      if (lows == 1 && prev_lows == 1) begin
        total++;
        if (drv != prev_drv) begin bad++; $display("FAIL driver_swap: %0d -> %0d", prev_drv, drv); end
      end
      if (lows == 0) idle_run++;
      else begin idle_run = 0; drv_seen = 1; end
      bus_prev  = (lows == 1) ? chip[drv] : 8'hxx;
      ld_prev   = bus.ld;
      prev_lows = lows;
      prev_drv  = drv;
    end
  end

  task automatic test_reset();
    mr_ = 1'b0;
    bus.req = '0; bus.xfer_src = '0; bus.xfer_dst = '0;
    for (int j = 0; j < R; j++) chip[j] = 8'($urandom_range(0, 255));
    repeat (3) tick();
    total++; if (bus.oe_  !== 4'b1111) begin bad++; $display("FAIL rst_oe: got %b want 1111", bus.oe_); end
    total++; if (bus.ld   !== 4'b0000) begin bad++; $display("FAIL rst_ld: got %b want 0000", bus.ld); end
    total++; if (bus.gnt  !== 4'b0000) begin bad++; $display("FAIL rst_gnt: got %b want 0000", bus.gnt); end
    total++; if (bus.done !== 4'b0000) begin bad++; $display("FAIL rst_done: got %b want 0000", bus.done); end
    total++; if (bus.err  !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", bus.err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    @(negedge cp); mr_ = 1'b1;
    tick();
    m_ptr = 0;
  endtask

  task automatic test_single();
    logic [7:0] exp_val;
    for (int t = 0; t < 30 && bus.busy !== 1'b0; t++) tick();
    set_xfer(0, 1, 3);
    exp_val = chip[1];
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    m_ptr = (rr_pick(4'b0001, m_ptr) + 1) % N;
    for (int c = 0; c <= S + 2 + T; c++) begin
      logic [R-1:0] e_oe, e_ld;
      logic [N-1:0] e_done, e_gnt;
      logic         e_busy;
      e_oe   = (c <= S) ? 4'b1101 : 4'b1111;
      e_ld   = (c == S) ? 4'b1000 : 4'b0000;
      e_done = (c == S + 1) ? 4'b0001 : 4'b0000;
      e_gnt  = (c <= S + 1) ? 4'b0001 : 4'b0000;
      e_busy = (c <= S + 1 + T);
      total++; if (bus.oe_ !== e_oe) begin bad++; $display("FAIL single_oe c=%0d: got %b want %b", c, bus.oe_, e_oe); end
      total++; if (bus.ld !== e_ld) begin bad++; $display("FAIL single_ld c=%0d: got %b want %b", c, bus.ld, e_ld); end
      total++; if ({bus.gnt, bus.done, bus.busy} !== {e_gnt, e_done, e_busy})
        begin bad++; $display("FAIL single_ctl c=%0d: gnt/done/busy got %b/%b/%b want %b/%b/%b",
                              c, bus.gnt, bus.done, bus.busy, e_gnt, e_done, e_busy); end
      if (c < S + 2 + T) tick();
    end
    total++; if (chip[3] !== exp_val) begin bad++; $display("FAIL single_data: reg3=%h want %h", chip[3], exp_val); end
  endtask

  task automatic test_reject();
    for (int t = 0; t < 30 && bus.busy !== 1'b0; t++) tick();
    set_xfer(2, 2, 2);
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    m_ptr = (rr_pick(4'b0100, m_ptr) + 1) % N;
    total++; if ({bus.gnt, bus.done, bus.err} !== {4'b0100, 4'b0100, 1'b1})
      begin bad++; $display("FAIL reject_pulse: gnt/done/err got %b/%b/%b want 0100/0100/1", bus.gnt, bus.done, bus.err); end
    total++; if ({bus.oe_, bus.ld} !== {4'b1111, 4'b0000})
      begin bad++; $display("FAIL reject_bus: oe_/ld got %b/%b want 1111/0000", bus.oe_, bus.ld); end
    tick();
    total++; if ({bus.gnt, bus.done, bus.err} !== {4'b0000, 4'b0000, 1'b0})
      begin bad++; $display("FAIL reject_clear: gnt/done/err got %b/%b/%b want 0000/0000/0", bus.gnt, bus.done, bus.err); end
  endtask

  task automatic test_wrap();
    int first;
    int w;
    for (int t = 0; t < 30 && bus.busy !== 1'b0; t++) tick();
    set_xfer(3, 0, 1);
    set_xfer(0, 2, 3);
    bus.req = 4'b1001;
    tick();
    first = cyc;
    w = rr_pick(4'b1001, m_ptr);
    total++; if (bus.gnt !== N'(1 << w)) begin bad++; $display("FAIL wrap_first: got %b want %b", bus.gnt, N'(1 << w)); end
    m_ptr = (w + 1) % N;
    for (int t = 0; t < 20 && bus.gnt !== '0; t++) tick();
    for (int t = 0; t < 20 && bus.gnt === '0; t++) tick();
    w = rr_pick(4'b1001, m_ptr);
    bus.req = '0;
    total++; if (bus.gnt !== N'(1 << w)) begin bad++; $display("FAIL wrap_second: got %b want %b", bus.gnt, N'(1 << w)); end
    total++; if (cyc - first !== PER) begin bad++; $display("FAIL wrap_period: got %0d want %0d", cyc - first, PER); end
    m_ptr = (w + 1) % N;
  endtask

  task automatic test_contention();
    int first, w;
    for (int t = 0; t < 30 && bus.busy !== 1'b0; t++) tick();
    for (int i = 0; i < N; i++) begin
      int s;
      s = $urandom_range(0, R - 1);
      set_xfer(i, s, (s + 1 + $urandom_range(0, R - 2)) % R);
    end
    bus.req = 4'b1111;
    first = 0;
    for (int g = 0; g < 5; g++) begin
      for (int t = 0; t < 20 && bus.gnt !== '0; t++) tick();
      for (int t = 0; t < 20 && bus.gnt === '0; t++) tick();
      w = rr_pick(4'b1111, m_ptr);
      total++; if (bus.gnt !== N'(1 << w)) begin bad++; $display("FAIL contend_gnt g=%0d: got %b want %b", g, bus.gnt, N'(1 << w)); end
      if (g > 0) begin
        total++; if (cyc - first !== PER) begin bad++; $display("FAIL contend_period g=%0d: got %0d want %0d", g, cyc - first, PER); end
      end
      first = cyc;
      m_ptr = (w + 1) % N;
    end
    bus.req = '0;
  endtask

  task automatic test_input_change();
    int s, d, w;
    logic [7:0] exp_val;
    for (int t = 0; t < 30 && bus.busy !== 1'b0; t++) tick();
    s = $urandom_range(0, R - 1);
    d = (s + 1 + $urandom_range(0, R - 2)) % R;
    set_xfer(1, s, d);
    exp_val = chip[s];
    bus.req = 4'b0010;
    tick();
    w = rr_pick(4'b0010, m_ptr);
    m_ptr = (w + 1) % N;
    set_xfer(1, d, (d + 1) % R);
    bus.req = '0;
    for (int c = 0; c <= S + 1; c++) begin
      logic [R-1:0] e_oe, e_ld;
      e_oe = (c <= S) ? ~R'(1 << s) : '1;
      e_ld = (c == S) ? R'(1 << d) : '0;
      total++; if ({bus.oe_, bus.ld} !== {e_oe, e_ld})
        begin bad++; $display("FAIL latch_bus c=%0d: oe_/ld got %b/%b want %b/%b", c, bus.oe_, bus.ld, e_oe, e_ld); end
      if (c < S + 1) tick();
    end
    total++; if (bus.done !== N'(1 << w)) begin bad++; $display("FAIL latch_done: got %b want %b", bus.done, N'(1 << w)); end
    tick();
    total++; if (chip[d] !== exp_val) begin bad++; $display("FAIL latch_data: reg%0d=%h want %h", d, chip[d], exp_val); end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 24; it++) begin
      logic [N-1:0] r;
      int           s [N];
      int           d [N];
      int           w;
      logic [7:0]   exp_val;
      for (int t = 0; t < 30 && bus.busy !== 1'b0; t++) tick();
      r = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        s[i] = $urandom_range(0, R - 1);
        d[i] = ($urandom_range(0, 3) == 0) ? s[i] : (s[i] + 1 + $urandom_range(0, R - 2)) % R;
        set_xfer(i, s[i], d[i]);
      end
      bus.req = r;
      tick();
      bus.req = '0;
      w = rr_pick(r, m_ptr);
      m_ptr = (w + 1) % N;
      exp_val = chip[s[w]];
      total++; if (bus.gnt !== N'(1 << w)) begin bad++; $display("FAIL rand_gnt it=%0d: got %b want %b", it, bus.gnt, N'(1 << w)); end
      if (s[w] == d[w]) begin
        total++; if ({bus.done, bus.err, bus.oe_} !== {N'(1 << w), 1'b1, 4'b1111})
          begin bad++; $display("FAIL rand_reject it=%0d: done/err/oe_ got %b/%b/%b", it, bus.done, bus.err, bus.oe_); end
      end else begin
        for (int c = 1; c <= S + 1; c++) begin
          tick();
          if (c == S) begin
            total++; if ({bus.ld, bus.oe_} !== {R'(1 << d[w]), ~R'(1 << s[w])})
              begin bad++; $display("FAIL rand_strobe it=%0d: ld/oe_ got %b/%b", it, bus.ld, bus.oe_); end
          end
        end
        total++; if ({bus.done, bus.err} !== {N'(1 << w), 1'b0})
          begin bad++; $display("FAIL rand_done it=%0d: done/err got %b/%b want %b/0", it, bus.done, bus.err, N'(1 << w)); end
        tick();
        total++; if (chip[d[w]] !== exp_val)
          begin bad++; $display("FAIL rand_data it=%0d: reg%0d=%h want %h", it, d[w], chip[d[w]], exp_val); end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] keep;
    for (int t = 0; t < 30 && bus.busy !== 1'b0; t++) tick();
    set_xfer(0, 1, 2);
    keep = chip[2];
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    total++; if ({bus.gnt, bus.oe_} !== {4'b0001, 4'b1101})
      begin bad++; $display("FAIL mrst_start: gnt/oe_ got %b/%b want 0001/1101", bus.gnt, bus.oe_); end
    tick();
    #2 mr_ = 1'b0;
    #1;
    total++; if ({bus.oe_, bus.ld, bus.gnt, bus.busy, bus.done} !== {4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0000})
      begin bad++; $display("FAIL mrst_async: oe_/ld/gnt/busy/done got %b/%b/%b/%b/%b", bus.oe_, bus.ld, bus.gnt, bus.busy, bus.done); end
    @(negedge cp); mr_ = 1'b1;
    m_ptr = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      total++; if ({bus.done, bus.ld} !== {4'b0000, 4'b0000})
        begin bad++; $display("FAIL mrst_quiet c=%0d: done/ld got %b/%b", c, bus.done, bus.ld); end
    end
    total++; if (chip[2] !== keep) begin bad++; $display("FAIL mrst_data: reg2=%h want %h", chip[2], keep); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reject();
    test_wrap();
    test_contention();
    test_input_change();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
